bcd_serial_accumulator: RTL and testbench
=========================================

// Module: bcd_serial_accumulator
// PURPOSE
//  N-digit BCD accumulator for score, lives and timer displays. Adds or subtracts an
//  arbitrary BCD delta, one digit per clock, through a req/ready/done handshake.
//  Commits the result atomically and saturates at the range limits.
//  Digit outputs drive the seven-segment and VGA number renderers directly.
// PARAMETERS
//  DIGITS     3      number of BCD digits (1..8); value range 0 .. 10^DIGITS-1
//  START_VAL  12'h100  BCD reset/load value, 4*DIGITS bits
//  ZERO_HOLD  1      1: a subtract request while value==0 is acknowledged but changes nothing
// PORTS
//  clk     in   1         clock
//  resetN  in   1         asynchronous reset, active-low
//  load    in   1         synchronous reload of START_VAL; highest priority
//  req     in   1         operation request; sampled only when ready=1
//  op      in   1         0=add, 1=subtract
//  delta   in   4*DIGITS  BCD operand; any digit >9 is clamped to 9 at capture
//  ready   out  1         1 in IDLE
//  done    out  1         1-cycle pulse; value is updated in the same cycle
//  value   out  4*DIGITS  committed BCD value, digit 0 = ones in [3:0]
//  zero    out  1         combinational: value==0
//  max     out  1         combinational: every digit of value ==9
//  sat     out  1         1-cycle pulse with done when the result clipped (or wrapped)
// BEHAVIOUR
//  Reset values: value=START_VAL, ready=1, done=0, sat=0; FSM in IDLE; shadow registers 0.
//  States:
//   IDLE: req&ready -> capture op and clamped delta, copy value to shadow, idx=0, cy=0 -> CALC.
//   CALC: shadow[idx] = value[idx] +/- delta[idx] +/- cy, with BCD correct (+6 / -6);
//         cy <= carry or borrow; idx++; after idx==DIGITS-1 -> COMMIT.
//   COMMIT: final cy=0 -> value<=shadow.
//           add with cy=1 -> value<=all 9s, sat=1.
//           sub with cy=1 -> value<=0, sat=1.
//           done=1 -> IDLE.
//  Latency: req accepted at edge T, done and new value at edge T+DIGITS+1; ready=0 in between.
//  value never shows a partial result; outputs change only in COMMIT or on load/reset.
//  ZERO_HOLD=1, op=1, value==0 at capture: skip CALC -> COMMIT next cycle.
//   value stays 0, done=1, sat=0.
//  delta==0: normal pass; value unchanged, done pulses.
//  load in any state: value<=START_VAL, FSM->IDLE, in-flight op discarded, no done pulse.
//  req while ready=0 is ignored (not queued); requester holds req until ready.
//  load and req in the same cycle: load wins, req is dropped.
// CONFIGURATION
//  BCD_WRAP_EN defined: overflow and underflow wrap modulo 10^DIGITS.
//   COMMIT always writes shadow; sat still pulses to flag the wrap.
//   Example: 999+1 -> 000; 000-1 -> 999.
//  BCD_WRAP_EN undefined: saturating behaviour as described above.
// STRUCTURE
//  Package bcd_pkg:
//   bcd_digit_t (logic [3:0]); BCD_MAX_DIGIT=4'd9.
//   op_e {OP_ADD, OP_SUB}; state_e {IDLE, CALC, COMMIT}.
//   Function bcd_clamp(d): returns d>9 ? 9 : d.
//  Sub-module bcd_digit_addsub (combinational):
//   Inputs a, b, cin, op. Outputs sum digit and cout.
//   One instance, muxed by idx; the top holds the FSM, index and shadow registers.
// TESTING  (DIGITS=3, START_VAL=100, ZERO_HOLD=1 unless stated)
//  1 Reset, then add 037.
//    -> ready falls; done at 4th edge after accept; value=137, sat=0.
//  2 value=099, add 001.
//    -> value=100 (ripple through 2 carries); sub 001 -> 099.
//  3 value=950, add 075.
//    -> value=999, sat=1.
//    -> with BCD_WRAP_EN: value=025, sat=1.
//  4 value=000, sub 005.
//    -> ZERO_HOLD=1: done in 2 cycles, value=000, sat=0.
//    -> ZERO_HOLD=0: value=000, sat=1; with BCD_WRAP_EN: value=995.
//  5 Assert load in mid-CALC during add 500.
//    -> value=100 next edge, no done pulse, ready=1.
//    -> req held during busy is accepted only after ready returns.
//  6 delta=0x0F3 (digit clamped to 9), add to 100.
//    -> value=193; zero/max track value (000 -> zero=1; 999 -> max=1).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD serial accumulator.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    typedef enum logic {OP_ADD, OP_SUB} op_e;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_e;

    // Force an out-of-range nibble into the legal BCD range.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single-digit BCD adder/subtractor with carry/borrow in and out.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  op_e        op,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;

    // Binary add/sub on one digit, then decimal correction (+6 on carry, -6 on borrow).
    always_comb begin
        raw  = '0;
        sum  = '0;
        cout = 1'b0;
        if (op == OP_SUB) begin
            raw  = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
            cout = raw[4];
            sum  = raw[4] ? (raw[3:0] - 4'd6) : raw[3:0];
        end else begin
            raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
            cout = (raw > 5'd9);
            sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
        end
    end

endmodule

// File: rtl/bcd_serial_accumulator.sv
// N-digit BCD accumulator: adds or subtracts a BCD delta one digit per clock,
// commits the result atomically and saturates at the range limits.
// Build option: define BCD_WRAP_EN to wrap modulo 10^DIGITS instead of saturating
// (sat still pulses to flag the wrap).
module bcd_serial_accumulator
    import bcd_pkg::*;
#(
    parameter int unsigned           DIGITS    = 3,
    parameter logic [4*DIGITS-1:0]   START_VAL = 12'h100,
    parameter bit                    ZERO_HOLD = 1'b1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                load,
    input  logic                req,
    input  logic                op,
    input  logic [4*DIGITS-1:0] delta,
    output logic                ready,
    output logic                done,
    output logic [4*DIGITS-1:0] value,
    output logic                zero,
    output logic                max,
    output logic                sat
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                     state_q, state_d;
    bcd_digit_t [DIGITS-1:0]    value_q, shadow_q, delta_q;
    op_e                        op_q;
    logic                       cy_q;
    logic                       hold_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       done_q, sat_q;

    logic                       accept;
    logic                       skip;
    logic                       last_digit;
    bcd_digit_t                 cur_sum;
    logic                       cur_cout;

    // A subtract from zero is acknowledged without touching the value.
    assign skip       = ZERO_HOLD && (op_e'(op) == OP_SUB) && (value_q == '0);
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

    bcd_digit_addsub u_digit (
        .a    (value_q[idx_q]),
        .b    (delta_q[idx_q]),
        .cin  (cy_q),
        .op   (op_q),
        .sum  (cur_sum),
        .cout (cur_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = skip ? COMMIT : CALC;
            CALC:    if (last_digit) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) state_d = IDLE;
    end

    // FSM-decoded outputs.
    always_comb begin
        ready  = (state_q == IDLE);
        accept = (state_q == IDLE) && req && !load;
    end

    // Datapath: capture, per-digit ripple into shadow, atomic commit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            value_q  <= START_VAL;
            shadow_q <= '0;
            delta_q  <= '0;
            op_q     <= OP_ADD;
            cy_q     <= 1'b0;
            hold_q   <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else if (load) begin
            value_q <= START_VAL;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            sat_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_e'(op);
                        for (int i = 0; i < int'(DIGITS); i++) begin
                            delta_q[i] <= bcd_clamp(delta[4*i +: 4]);
                        end
                        shadow_q <= value_q;
                        idx_q    <= '0;
                        cy_q     <= 1'b0;
                        hold_q   <= skip;
                    end
                end
                CALC: begin
                    shadow_q[idx_q] <= cur_sum;
                    cy_q            <= cur_cout;
                    idx_q           <= idx_q + 1'b1;
                end
                COMMIT: begin
                    done_q <= 1'b1;
                    if (hold_q) begin
                        value_q <= value_q;
                    end else if (!cy_q) begin
                        value_q <= shadow_q;
                    end else begin
                        sat_q <= 1'b1;
`ifdef BCD_WRAP_EN
                        value_q <= shadow_q;
`else
                        value_q <= (op_q == OP_ADD) ? {DIGITS{BCD_MAX_DIGIT}} : '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags derived from the committed value.
    always_comb begin
        zero = (value_q == '0);
        max  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (value_q[i] != BCD_MAX_DIGIT) max = 1'b0;
        end
    end

    assign value = value_q;
    assign done  = done_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
// Self-checking bench for bcd_serial_accumulator (DIGITS=3, START_VAL=100, ZERO_HOLD=1).
module tb_bcd_serial_accumulator;

    localparam int K_ADD  = 0;
    localparam int K_SUB  = 1;
    localparam int K_LOAD = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic        load, req, op;
    logic [11:0] delta;
    logic        ready, done, zero, max, sat;
    logic [11:0] value;

    int checks = 0;
    int errors = 0;

    bcd_serial_accumulator #(
        .DIGITS    (3),
        .START_VAL (12'h100),
        .ZERO_HOLD (1'b1)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .load   (load),
        .req    (req),
        .op     (op),
        .delta  (delta),
        .ready  (ready),
        .done   (done),
        .value  (value),
        .zero   (zero),
        .max    (max),
        .sat    (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [11:0] d;
        logic [11:0] exp_val;
        logic        exp_sat;
        int          exp_lat;
    } row_t;

    row_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int clamped(input logic [11:0] b);
        logic [11:0] c;
        c = b;
        for (int i = 0; i < 3; i++) begin
            if (c[4*i +: 4] > 4'd9) c[4*i +: 4] = 4'd9;
        end
        return bcd2int(c);
    endfunction

    // Reference: plain integer arithmetic on the decimal value.
    task automatic model(input int v, input logic o, input logic [11:0] d,
                         output int nv, output logic s, output int lat);
        int r;
        s   = 1'b0;
        lat = 4;
        if (o && v == 0) begin
            nv  = 0;
            lat = 1;
        end else begin
            r = o ? v - clamped(d) : v + clamped(d);
            if (r > 999) begin
                s = 1'b1;
`ifdef BCD_WRAP_EN
                r = r - 1000;
`else
                r = 999;
`endif
            end else if (r < 0) begin
                s = 1'b1;
`ifdef BCD_WRAP_EN
                r = r + 1000;
`else
                r = 0;
`endif
            end
            nv = r;
        end
    endtask

    // Issue one request and count edges after acceptance until done.
    task automatic run_op(input logic o, input logic [11:0] d,
                          output int lat, output logic bad, output logic s);
        logic [11:0] v0;
        @(negedge clk);
        v0    = value;
        req   = 1'b1;
        op    = o;
        delta = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        bad = 1'b0;
        s   = 1'b0;
        while (lat < 20) begin
            if (!done && (ready || value != v0)) bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                s = sat;
                break;
            end
        end
    endtask

    task automatic do_load();
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        bad, s;
        int          mv, nv, elat;
        logic        es;
        logic        o;
        logic [11:0] d;
        logic        seen;

        tbl[0]  = '{K_ADD,  12'h037, 12'h137, 1'b0, 4};
        tbl[1]  = '{K_SUB,  12'h038, 12'h099, 1'b0, 4};
        tbl[2]  = '{K_ADD,  12'h001, 12'h100, 1'b0, 4};
        tbl[3]  = '{K_SUB,  12'h001, 12'h099, 1'b0, 4};
        tbl[4]  = '{K_ADD,  12'h851, 12'h950, 1'b0, 4};
`ifdef BCD_WRAP_EN
        tbl[5]  = '{K_ADD,  12'h075, 12'h025, 1'b1, 4};
`else
        tbl[5]  = '{K_ADD,  12'h075, 12'h999, 1'b1, 4};
`endif
        tbl[6]  = '{K_LOAD, 12'h000, 12'h100, 1'b0, 0};
        tbl[7]  = '{K_SUB,  12'h100, 12'h000, 1'b0, 4};
        tbl[8]  = '{K_SUB,  12'h005, 12'h000, 1'b0, 1};
        tbl[9]  = '{K_LOAD, 12'h000, 12'h100, 1'b0, 0};
        tbl[10] = '{K_ADD,  12'h0F3, 12'h193, 1'b0, 4};
        tbl[11] = '{K_ADD,  12'h806, 12'h999, 1'b0, 4};
        tbl[12] = '{K_ADD,  12'h000, 12'h999, 1'b0, 4};
        tbl[13] = '{K_SUB,  12'h999, 12'h000, 1'b0, 4};
        tbl[14] = '{K_ADD,  12'h0FF, 12'h099, 1'b0, 4};
`ifdef BCD_WRAP_EN
        tbl[15] = '{K_SUB,  12'h100, 12'h999, 1'b1, 4};
`else
        tbl[15] = '{K_SUB,  12'h100, 12'h000, 1'b1, 4};
`endif
        tbl[16] = '{K_LOAD, 12'h000, 12'h100, 1'b0, 0};

        resetN = 1'b0;
        load   = 1'b0;
        req    = 1'b0;
        op     = 1'b0;
        delta  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;

        check("reset_value", 32'(value), 32'h100);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done",  32'(done),  32'd0);
        check("reset_sat",   32'(sat),   32'd0);
        check("reset_zero",  32'(zero),  32'd0);
        check("reset_max",   32'(max),   32'd0);

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].kind == K_LOAD) begin
                do_load();
                check($sformatf("row%0d_load_value", i), 32'(value), 32'(tbl[i].exp_val));
                check($sformatf("row%0d_load_done", i), 32'(done), 32'd0);
                check($sformatf("row%0d_load_ready", i), 32'(ready), 32'd1);
            end else begin
                run_op(tbl[i].kind == K_SUB, tbl[i].d, lat, bad, s);
                check($sformatf("row%0d_value", i), 32'(value), 32'(tbl[i].exp_val));
                check($sformatf("row%0d_sat", i), 32'(s), 32'(tbl[i].exp_sat));
                check($sformatf("row%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
                check($sformatf("row%0d_busy_clean", i), 32'(bad), 32'd0);
                check($sformatf("row%0d_zero", i), 32'(zero), 32'(tbl[i].exp_val == 12'h000));
                check($sformatf("row%0d_max", i), 32'(max), 32'(tbl[i].exp_val == 12'h999));
            end
        end

        // Load in mid-CALC with req held through the busy period.
        @(negedge clk);
        req   = 1'b1;
        op    = 1'b0;
        delta = 12'h500;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("abort_value", 32'(value), 32'h100);
        check("abort_done",  32'(done),  32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("held_req_accepted", 32'(ready), 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("held_req_latency", 32'(lat), 32'd4);
        check("held_req_value", 32'(value), 32'h600);

        // Load and req together: load wins, req dropped.
        @(negedge clk);
        load  = 1'b1;
        req   = 1'b1;
        op    = 1'b0;
        delta = 12'h001;
        @(posedge clk);
        #1;
        load = 1'b0;
        req  = 1'b0;
        check("load_req_ready", 32'(ready), 32'd1);
        check("load_req_value", 32'(value), 32'h100);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("load_req_no_done", 32'(seen), 32'd0);
        check("load_req_final", 32'(value), 32'h100);

        // Randomized ops against the integer model.
        mv = 100;
        for (int n = 0; n < 150; n++) begin
            o = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = 12'($urandom_range(0, 15));
            else d = 12'($urandom);
            model(mv, o, d, nv, es, elat);
            run_op(o, d, lat, bad, s);
            check($sformatf("rnd%0d_value", n), 32'(value), 32'(int2bcd(nv)));
            check($sformatf("rnd%0d_sat", n), 32'(s), 32'(es));
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_busy_clean", n), 32'(bad), 32'd0);
            mv = nv;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
